// File: rtl/pi_error_ramp_pkg.sv
// Shared constants, FSM encoding and float compare helper for pi_error_ramp.
// Defines the SINGLE width macro used by the other pi_error_ramp files.
`define SINGLE 32

package pi_error_ramp_pkg;

   localparam logic [`SINGLE-1:0] FP_ZERO = 32'h0000_0000;
   localparam logic [`SINGLE-1:0] FP_ONE  = 32'h3F80_0000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RSTEP  = 3'd1,
      ST_RWAIT  = 3'd2,
      ST_RCLAMP = 3'd3,
      ST_ESUB   = 3'd4,
      ST_EWAIT  = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   // Sign-magnitude a > b on raw IEEE754 bits; +0 and -0 compare equal.
   function automatic logic fp_gt(input logic [`SINGLE-1:0] a, input logic [`SINGLE-1:0] b);
      logic a_zero;
      logic b_zero;
      a_zero = (a[30:0] == 31'd0);
      b_zero = (b[30:0] == 31'd0);
      if (a_zero && b_zero) begin
         fp_gt = 1'b0;
      end else if (a[31] != b[31]) begin
         fp_gt = b[31];
      end else if (a[31] == 1'b0) begin
         fp_gt = (a[30:0] > b[30:0]);
      end else begin
         fp_gt = (a[30:0] < b[30:0]);
      end
   endfunction

endpackage

// File: rtl/pi_err_addsub.sv
// Operand mux plus pipelined single-precision adder with add/sub select.
// The sum and a valid flag travel together through ADD_LAT register stages.
module pi_err_addsub
   import pi_error_ramp_pkg::*;
#(
   parameter int ADD_LAT = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush_i,
   input  logic               issue_i,
   input  logic               sel_err_i,
   input  logic               sub_i,
   input  logic [`SINGLE-1:0] ref_i,
   input  logic [`SINGLE-1:0] step_i,
   input  logic [`SINGLE-1:0] meas_i,
   output logic [`SINGLE-1:0] sum_o,
   output logic               valid_o
);

   // Round-to-nearest-even float add; NaN/Inf and exponent overflow are not handled.
   function automatic logic [`SINGLE-1:0] fp_add(input logic [`SINGLE-1:0] a, input logic [`SINGLE-1:0] b);
      logic [31:0] big, sml;
      logic [8:0]  eb, es, diff, er;
      logic [26:0] mb, ms, mask, norm;
      logic [27:0] sum;
      logic [4:0]  lz;
      logic        sticky, rnd;
      logic [30:0] mag;
      if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
      else begin big = b; sml = a; end
      eb = (big[30:23] == 8'd0) ? 9'd1 : {1'b0, big[30:23]};
      es = (sml[30:23] == 8'd0) ? 9'd1 : {1'b0, sml[30:23]};
      mb = {(big[30:23] != 8'd0), big[22:0], 3'b000};
      ms = {(sml[30:23] != 8'd0), sml[22:0], 3'b000};
      diff = eb - es;
      if (diff > 9'd26) begin
         sticky = |ms;
         ms = 27'd0;
      end else begin
         mask = (27'd1 << diff[4:0]) - 27'd1;
         sticky = |(ms & mask);
         ms = ms >> diff[4:0];
      end
      ms[0] = ms[0] | sticky;
      if (big[31] == sml[31]) sum = {1'b0, mb} + {1'b0, ms};
      else sum = {1'b0, mb} - {1'b0, ms};
      lz = 5'd0;
      for (int i = 0; i < 27; i++) begin
         if (sum[i]) lz = 5'(26 - i);
      end
      if (sum[27]) begin
         norm = {sum[27:2], sum[1] | sum[0]};
         er = eb + 9'd1;
      end else if (eb > {4'd0, lz}) begin
         norm = sum[26:0] << lz;
         er = eb - {4'd0, lz};
      end else begin
         // Result is subnormal: shift only as far as the minimum exponent allows.
         norm = sum[26:0] << (eb[4:0] - 5'd1);
         er = 9'd0;
      end
      rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
      mag = {er[7:0], norm[25:3]} + {30'd0, rnd};
      if (sum == 28'd0) fp_add = FP_ZERO;
      else fp_add = {big[31], mag};
   endfunction

   logic [`SINGLE-1:0] opb_s;
   logic [`SINGLE-1:0] sum_s;
   logic [`SINGLE-1:0] data_q [ADD_LAT];
   logic [ADD_LAT-1:0] vld_q;

   // Second operand select and sign flip for subtraction.
   always_comb begin
      opb_s = (sel_err_i ? meas_i : step_i) ^ {sub_i, 31'd0};
      sum_s = fp_add(ref_i, opb_s);
   end

   // Latency pipeline; a flush drops any in-flight result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         for (int i = 0; i < ADD_LAT; i++) data_q[i] <= FP_ZERO;
      end else if (flush_i) begin
         vld_q <= '0;
         for (int i = 0; i < ADD_LAT; i++) data_q[i] <= FP_ZERO;
      end else begin
         data_q[0] <= sum_s;
         vld_q[0]  <= issue_i;
         for (int i = 1; i < ADD_LAT; i++) begin
            data_q[i] <= data_q[i-1];
            vld_q[i]  <= vld_q[i-1];
         end
      end
   end

   assign sum_o   = data_q[ADD_LAT-1];
   assign valid_o = vld_q[ADD_LAT-1];

endmodule

// File: rtl/pi_error_ramp.sv
// PI front end: per control period, step ref_ramped toward ref_target, then x = ref_ramped - meas.
// Build option PI_REF_RAMP_EN enables the bounded ramp; without it ref_ramped follows ref_target.
module pi_error_ramp
   import pi_error_ramp_pkg::*;
#(
   parameter int                 ADD_LAT  = 7,
   parameter logic [`SINGLE-1:0] STEP     = 32'h3DCC_CCCD,
   parameter logic [`SINGLE-1:0] REF_INIT = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rst_user,
   input  logic               sta,
   input  logic [`SINGLE-1:0] ref_target,
   input  logic [`SINGLE-1:0] meas,
   output logic [`SINGLE-1:0] x,
   output logic               sta_out,
   output logic [`SINGLE-1:0] ref_ramped,
   output logic               busy
);

   localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [`SINGLE-1:0] meas_q, meas_d, ref_q, ref_d, x_q, x_d, res_q, sum_s;
   logic               sta_out_q, sta_out_d, busy_q, busy_d;
   logic               issue_s, sel_err_s, sub_s, add_vld_s;
`ifdef PI_REF_RAMP_EN
   logic [`SINGLE-1:0] tgt_q, tgt_d;
   logic               dir_up_q, dir_up_d, pass_s, eq_s;
`endif

   pi_err_addsub #(.ADD_LAT(ADD_LAT)) u_addsub (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (rst_user),
      .issue_i   (issue_s),
      .sel_err_i (sel_err_s),
      .sub_i     (sub_s),
      .ref_i     (ref_q),
      .step_i    (STEP),
      .meas_i    (meas_q),
      .sum_o     (sum_s),
      .valid_o   (add_vld_s)
   );

   // Next-state and datapath control.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      meas_d    = meas_q;
      ref_d     = ref_q;
      x_d       = x_q;
      sta_out_d = 1'b0;
      issue_s   = 1'b0;
      sel_err_s = 1'b0;
      sub_s     = 1'b0;
`ifdef PI_REF_RAMP_EN
      tgt_d    = tgt_q;
      dir_up_d = dir_up_q;
      pass_s   = dir_up_q ? fp_gt(res_q, tgt_q) : fp_gt(tgt_q, res_q);
      eq_s     = !fp_gt(tgt_q, ref_q) && !fp_gt(ref_q, tgt_q);
`endif
      if (rst_user) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         ref_d   = REF_INIT;
         x_d     = FP_ZERO;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sta) begin
                  meas_d = meas;
`ifdef PI_REF_RAMP_EN
                  tgt_d    = ref_target;
                  dir_up_d = fp_gt(ref_target, ref_q);
                  state_d  = ST_RSTEP;
`else
                  ref_d   = ref_target;
                  state_d = ST_ESUB;
`endif
               end else begin
                  state_d = ST_IDLE;
               end
            end
`ifdef PI_REF_RAMP_EN
            ST_RSTEP: begin
               issue_s = 1'b1;
               sub_s   = ~dir_up_q;
               cnt_d   = '0;
               state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
               if (cnt_q == CW'(ADD_LAT - 1)) state_d = ST_RCLAMP;
               else cnt_d = cnt_q + CW'(1);
            end
            ST_RCLAMP: begin
               // The equal case still runs the step so latency never depends on data.
               if (pass_s || eq_s) ref_d = tgt_q;
               else ref_d = res_q;
               state_d = ST_ESUB;
            end
`endif
            ST_ESUB: begin
               issue_s   = 1'b1;
               sel_err_s = 1'b1;
               sub_s     = 1'b1;
               cnt_d     = '0;
               state_d   = ST_EWAIT;
            end
            ST_EWAIT: begin
               if (cnt_q == CW'(ADD_LAT - 1)) state_d = ST_DONE;
               else cnt_d = cnt_q + CW'(1);
            end
            ST_DONE: begin
               x_d       = res_q;
               sta_out_d = 1'b1;
               state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d = (state_d != ST_IDLE) || sta_out_d;
   end

   // FSM, counter and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         meas_q    <= FP_ZERO;
         ref_q     <= REF_INIT;
         x_q       <= FP_ZERO;
         sta_out_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         meas_q    <= meas_d;
         ref_q     <= ref_d;
         x_q       <= x_d;
         sta_out_q <= sta_out_d;
         busy_q    <= busy_d;
      end
   end

   // Hold the latest adder result for the clamp and DONE states.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) res_q <= FP_ZERO;
      else if (rst_user) res_q <= FP_ZERO;
      else if (add_vld_s) res_q <= sum_s;
      else res_q <= res_q;
   end

`ifdef PI_REF_RAMP_EN
   // Target and step direction of the operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tgt_q    <= FP_ZERO;
         dir_up_q <= 1'b0;
      end else begin
         tgt_q    <= tgt_d;
         dir_up_q <= dir_up_d;
      end
   end
`endif

   assign x          = x_q;
   assign sta_out    = sta_out_q;
   assign ref_ramped = ref_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_pi_error_ramp.sv
// Directed, table-driven bench for pi_error_ramp (STEP=0.5, REF_INIT=0, ADD_LAT=7).
// Expectations follow whichever PI_REF_RAMP_EN setting the bundle is compiled with.
module tb_pi_error_ramp;

`ifdef PI_REF_RAMP_EN
   localparam int LAT = 19;
   localparam int RU  = 10;
   localparam logic [31:0] C1_REF = 32'h3F00_0000;
   localparam logic [31:0] RU_PRE = 32'h3FC0_0000;
   localparam logic [31:0] F_REF  = 32'h3F00_0000;
`else
   localparam int LAT = 10;
   localparam int RU  = 5;
   localparam logic [31:0] C1_REF = 32'h3F80_0000;
   localparam logic [31:0] RU_PRE = 32'h4000_0000;
   localparam logic [31:0] F_REF  = 32'h3F80_0000;
`endif

   typedef struct {
      logic        clr;
      logic [31:0] tgt;
      logic [31:0] ms;
      logic [31:0] exp_ref;
      logic [31:0] exp_x;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rst_user = 1'b0;
   logic        sta = 1'b0;
   logic [31:0] ref_target = 32'h0;
   logic [31:0] meas = 32'h0;
   logic [31:0] x;
   logic        sta_out;
   logic [31:0] ref_ramped;
   logic        busy;

   int n_chk = 0;
   int n_fail = 0;
   vec_t vecs [8];

   pi_error_ramp #(
      .ADD_LAT  (7),
      .STEP     (32'h3F00_0000),
      .REF_INIT (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rst_user   (rst_user),
      .sta        (sta),
      .ref_target (ref_target),
      .meas       (meas),
      .x          (x),
      .sta_out    (sta_out),
      .ref_ramped (ref_ramped),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      rst_user = 1'b1;
      sta = 1'b1;
      step();
      rst_user = 1'b0;
      sta = 1'b0;
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_ref", ref_ramped, 32'h0);
      step();
   endtask

   task automatic do_op(input string nm, input logic [31:0] tgt, input logic [31:0] ms,
                        input logic [31:0] er, input logic [31:0] ex);
      int lat = 0;
      int pulses = 0;
      int busy_cnt = 0;
      logic [31:0] got_ref = 32'hDEAD_BEEF;
      logic [31:0] got_x = 32'hDEAD_BEEF;
      ref_target = tgt;
      meas = ms;
      sta = 1'b1;
      step();
      sta = 1'b0;
      for (int k = 1; k <= LAT + 4; k++) begin
         if (busy) busy_cnt++;
         if (sta_out) begin
            pulses++;
            if (lat == 0) begin
               lat = k;
               got_ref = ref_ramped;
               got_x = x;
            end
         end
         step();
      end
      chk({nm, "_lat"}, 32'(lat), 32'(LAT));
      chk({nm, "_pulses"}, 32'(pulses), 32'd1);
      chk({nm, "_busy"}, 32'(busy_cnt), 32'(LAT));
      chk({nm, "_ref"}, got_ref, er);
      chk({nm, "_x"}, got_x, ex);
   endtask

   initial begin
      int pulses;
      int first;
      int second;
      logic [31:0] r1, x1, r2, x2;

`ifdef PI_REF_RAMP_EN
      vecs[0] = '{1'b0, 32'h3F80_0000, 32'h0000_0000, 32'h3F00_0000, 32'h3F00_0000};
      vecs[1] = '{1'b0, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000};
      vecs[2] = '{1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000};
      vecs[3] = '{1'b0, 32'h3E80_0000, 32'h0000_0000, 32'h3F00_0000, 32'h3F00_0000};
      vecs[4] = '{1'b0, 32'h3E80_0000, 32'h0000_0000, 32'h3E80_0000, 32'h3E80_0000};
      vecs[5] = '{1'b1, 32'h3E80_0000, 32'h0000_0000, 32'h3E80_0000, 32'h3E80_0000};
      vecs[6] = '{1'b1, 32'hBF80_0000, 32'h3F00_0000, 32'hBF00_0000, 32'hBF80_0000};
      vecs[7] = '{1'b0, 32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000, 32'hC000_0000};
`else
      vecs[0] = '{1'b1, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000};
      vecs[1] = '{1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000};
      vecs[2] = '{1'b0, 32'h3F00_0000, 32'h3F80_0000, 32'h3F00_0000, 32'hBF00_0000};
      vecs[3] = '{1'b0, 32'hC040_0000, 32'h3FC0_0000, 32'hC040_0000, 32'hC090_0000};
      vecs[4] = '{1'b0, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000};
      vecs[5] = '{1'b1, 32'h3E80_0000, 32'h3E80_0000, 32'h3E80_0000, 32'h0000_0000};
      vecs[6] = '{1'b0, 32'h4040_0000, 32'h3F80_0000, 32'h4040_0000, 32'h4000_0000};
      vecs[7] = '{1'b0, 32'h0000_0000, 32'hBF80_0000, 32'h0000_0000, 32'h3F80_0000};
`endif

      // Reset held with sta asserted: outputs must stay at reset values.
      rst = 1'b0;
      sta = 1'b1;
      ref_target = 32'h3F80_0000;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("rst_x", x, 32'h0);
         chk("rst_sta_out", 32'(sta_out), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_ref", ref_ramped, 32'h0);
      end
      sta = 1'b0;
      rst = 1'b1;
      step();

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].clr) clr();
         do_op($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].ms, vecs[i].exp_ref, vecs[i].exp_x);
      end

      // sta while busy and in DONE is ignored; sta right after DONE is accepted.
      clr();
      ref_target = 32'h3F80_0000;
      meas = 32'h0;
      pulses = 0; first = 0; second = 0;
      r1 = 32'h0; x1 = 32'h0; r2 = 32'h0; x2 = 32'h0;
      for (int k = 0; k <= 2 * LAT + 3; k++) begin
         sta = (k == 0 || k == 5 || k == LAT - 1 || k == LAT);
         step();
         if (sta_out) begin
            pulses++;
            if (first == 0) begin first = k + 1; r1 = ref_ramped; x1 = x; end
            else begin second = k + 1; r2 = ref_ramped; x2 = x; end
         end
      end
      sta = 1'b0;
      chk("cont_pulses", 32'(pulses), 32'd2);
      chk("cont_first", 32'(first), 32'(LAT));
      chk("cont_second", 32'(second), 32'(2 * LAT));
      chk("cont_ref1", r1, C1_REF);
      chk("cont_x1", x1, C1_REF);
      chk("cont_ref2", r2, 32'h3F80_0000);
      chk("cont_x2", x2, 32'h3F80_0000);

      // rst_user mid-operation abandons it without a pulse.
      ref_target = 32'h4000_0000;
      meas = 32'h0;
      pulses = 0;
      for (int k = 0; k <= LAT + 3; k++) begin
         sta = (k == 0);
         rst_user = (k == RU);
         step();
         if (sta_out) pulses++;
         if (k + 1 == RU) chk("ru_ref_pre", ref_ramped, RU_PRE);
         if (k + 1 == RU + 1) begin
            chk("ru_ref", ref_ramped, 32'h0);
            chk("ru_busy", 32'(busy), 32'd0);
            chk("ru_x", x, 32'h0);
         end
      end
      sta = 1'b0;
      rst_user = 1'b0;
      chk("ru_pulses", 32'(pulses), 32'd0);

      do_op("post_ru", 32'h3F80_0000, 32'h0, F_REF, F_REF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
